rca_arbiter: RTL
================

# rca_arbiter

Two-requester round-robin arbiter that time-shares one registered ripple-carry adder (`RCA`, parameter `WIDTH`, two-cycle latency) between independent clients. It accepts one add request per cycle via a valid/ready handshake and drives the adder's `a`/`b`/`cin` inputs. It tags each issued operation and routes the adder's `sum` back to the originating requester as a one-cycle response pulse. It sits between client logic and a single `RCA` instance, sharing the same `clk`/`rst`.

## Interface
- `WIDTH`, 4, operand width; must equal the attached `RCA` `WIDTH`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high; also drives the attached `RCA`.
- `req0_valid`, `req1_valid`  in  1  request present.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_cin`, `req1_cin`  in  1  carry-in.
- `rsp0_valid`, `rsp1_valid`  out  1  result pulse for requester 0 / 1.
- `rsp_sum`  out  WIDTH+1  result, shared; qualified by `rspN_valid`.
- `add_a`, `add_b`  out  WIDTH  to `RCA` `a`/`b`.
- `add_cin`  out  1  to `RCA` `cin`.
- `add_sum`  in  WIDTH+1  from `RCA` `sum`.
- `inflight`  out  2  operations issued and not yet returned (0..2).

## Operation
- Grant, combinational per cycle:
  - one valid → that requester;
  - both valid → the requester not granted most recently;
  - none valid → no grant.
- `reqN_ready` = grant to N. Ready depends on valid; requesters must not make valid depend on ready.
- Handshake completes when `reqN_valid && reqN_ready`. Requesters hold operands stable while valid and not ready.
- `add_a`/`add_b`/`add_cin` = granted requester's operands. With no grant they are 0, so the adder computes 0.
- Last-grant pointer updates only on a grant. Its reset value is "1 last", so requester 0 wins the first contention.
- Tag pipeline: two stages, each {valid, id}. Stage 0 loads {grant, id} each cycle; stage 1 loads stage 0.
- `rspN_valid` = stage1.valid && stage1.id == N. `rsp_sum` = `add_sum` passed through combinationally.
- No response backpressure. Requesters must take the result in the pulse cycle.
- `inflight` = stage0.valid + stage1.valid.
- Sum width is WIDTH+1. Bit WIDTH is the adder carry-out, so no overflow is possible.

## Timing
- Request accepted in cycle t → `add_*` valid in cycle t → `RCA` captures at the end of t → `rspN_valid` high in cycle t+2 only.
- Throughput: one operation per cycle, any mix of requesters. Responses return in issue order.
- Both requesters valid continuously → grants alternate 0,1,0,1…, starting with 0 after reset.
- A requester valid alone is granted every cycle. The pointer still updates, so the other requester wins the next contention.
- Reset:
  - in any cycle with `rst`=1, `req0_ready`=`req1_ready`=0 and `add_*`=0;
  - the next cycle, tag stages, pointer and `inflight` are 0 and `rsp0_valid`=`rsp1_valid`=0;
  - `rsp_sum` follows `RCA`, which is also cleared, so it reads 0.
- Reset mid-operation: in-flight operations are discarded and no response pulse is emitted for them. Requests presented during reset are not accepted.
- First grant is possible in the first cycle with `rst`=0.

## Configuration
- `RCA_ARB_STATS_EN` defined adds outputs `gnt0_cnt` and `gnt1_cnt`, 16 bits each.
  - Each counts accepted requests for its requester.
  - Saturates at 16'hFFFF.
  - Cleared by `rst`.
  - Visible one cycle after the grant.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Single request, WIDTH=4:
  - stimulus: req0 a=4'hF, b=4'h1, cin=0, accepted in cycle t;
  - response: `rsp0_valid` only in t+2, `rsp_sum`=5'h10, `rsp1_valid` stays 0, `inflight`=1 in t+1 and t+2 and 0 in t+3.
- Contention:
  - stimulus: both valid for 4 cycles, req0 (3,4,cin 1), req1 (7,7,cin 0);
  - response: grants 0,1,0,1, responses alternate rsp0=8, rsp1=14, each 2 cycles after its grant, `inflight` holds 2.
- Held request:
  - stimulus: req1 held valid while req0 wins;
  - response: req1 operands unchanged and granted the next cycle, result 2 cycles after its own grant.
- Back-to-back solo:
  - stimulus: req0 issues 5 consecutive adds 0+0, 1+1, …, 4+4, cin=1;
  - response: rsp0 pulses on 5 consecutive cycles with sums 1, 3, 5, 7, 9.
- Reset mid-flight:
  - stimulus: `rst` one cycle after two issues;
  - response: no response pulses appear, and `inflight`=0, readies 0 during reset, first post-reset contention granted to req0.
- `RCA_ARB_STATS_EN`:
  - stimulus: 70000 req0 grants and 3 req1 grants;
  - response: `gnt0_cnt`=16'hFFFF, `gnt1_cnt`=3, both 0 after `rst`.

Source files
------------

// File: rtl/rca_arbiter_if.sv
// rca_arbiter_if: request, response and adder bundle for rca_arbiter.
// Optional feature macro: RCA_ARB_STATS_EN (adds gnt0_cnt/gnt1_cnt).
//
// Handshake: reqN transfers in any cycle where reqN_valid && reqN_ready.
// Ready is derived from valid, so valid must never depend on ready, and the
// operands must stay stable while valid is high and ready is low.
// rspN_valid is a single-cycle pulse with no backpressure, and rsp_sum is
// meaningful only while one of the rspN_valid pulses is high.
interface rca_arbiter_if #(parameter int WIDTH = 4);
    logic             req0_valid;
    logic             req1_valid;
    logic             req0_ready;
    logic             req1_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req0_cin;
    logic             req1_cin;
    logic             rsp0_valid;
    logic             rsp1_valid;
    logic [WIDTH:0]   rsp_sum;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   add_sum;
    logic [1:0]       inflight;
`ifdef RCA_ARB_STATS_EN
    logic [15:0]      gnt0_cnt;
    logic [15:0]      gnt1_cnt;
`endif

    // Arbiter side
    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, add_sum,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_sum,
               add_a, add_b, add_cin, inflight
`ifdef RCA_ARB_STATS_EN
        , output gnt0_cnt, gnt1_cnt
`endif
    );

    // Client and adder side
    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_cin, req1_cin, add_sum,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_sum,
               add_a, add_b, add_cin, inflight
`ifdef RCA_ARB_STATS_EN
        , input gnt0_cnt, gnt1_cnt
`endif
    );
endinterface

// File: rtl/rca_arbiter.sv
// rca_arbiter: round-robin sharing of one registered two-cycle ripple-carry
// adder between two requesters. Each issued operation is tagged with its
// requester id, and the tag travels beside the adder pipeline so that the
// sum returns as a one-cycle pulse to the right requester.
// Optional feature macro: RCA_ARB_STATS_EN adds saturating 16-bit per-requester
// grant counters (gnt0_cnt/gnt1_cnt).
module rca_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    rca_arbiter_if.slave bus
);
    logic gnt0;
    logic gnt1;
    // 0: requester 0 wins the next contention (reset means "1 was last")
    logic prio_q, prio_d;
    // Tag stages track the two adder register stages
    logic s0_valid_q, s0_valid_d;
    logic s0_id_q, s0_id_d;
    logic s1_valid_q, s1_valid_d;
    logic s1_id_q, s1_id_d;

    // Grant: single requester wins outright, contention alternates, none in reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = ~prio_q;
                gnt1 = prio_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;

    // Adder inputs come from the granted requester; zero when idle
    assign bus.add_a   = gnt0 ? bus.req0_a   : (gnt1 ? bus.req1_a   : {WIDTH{1'b0}});
    assign bus.add_b   = gnt0 ? bus.req0_b   : (gnt1 ? bus.req1_b   : {WIDTH{1'b0}});
    assign bus.add_cin = gnt0 ? bus.req0_cin : (gnt1 ? bus.req1_cin : 1'b0);

    // Next state: pointer moves only on a grant, tags shift every cycle
    always_comb begin
        prio_d = prio_q;
        if (gnt0) begin
            prio_d = 1'b1;
        end else if (gnt1) begin
            prio_d = 1'b0;
        end
        s0_valid_d = gnt0 | gnt1;
        s0_id_d    = gnt1;
        s1_valid_d = s0_valid_q;
        s1_id_d    = s0_id_q;
    end

    // Pointer and tag registers; reset drops any in-flight tags
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= 1'b0;
            s0_valid_q <= 1'b0;
            s0_id_q    <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_id_q    <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            s0_valid_q <= s0_valid_d;
            s0_id_q    <= s0_id_d;
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
        end
    end

    // Responses are masked while rst is high so discarded work never pulses
    assign bus.rsp0_valid = ~rst & s1_valid_q & ~s1_id_q;
    assign bus.rsp1_valid = ~rst & s1_valid_q & s1_id_q;
    assign bus.rsp_sum    = bus.add_sum;
    assign bus.inflight   = {1'b0, s0_valid_q} + {1'b0, s1_valid_q};

`ifdef RCA_ARB_STATS_EN
    logic [15:0] gnt0_cnt_q, gnt0_cnt_d;
    logic [15:0] gnt1_cnt_q, gnt1_cnt_d;

    // Saturating accepted-request counters
    always_comb begin
        gnt0_cnt_d = gnt0_cnt_q;
        gnt1_cnt_d = gnt1_cnt_q;
        if (gnt0 && (gnt0_cnt_q != 16'hFFFF)) begin
            gnt0_cnt_d = gnt0_cnt_q + 16'd1;
        end
        if (gnt1 && (gnt1_cnt_q != 16'hFFFF)) begin
            gnt1_cnt_d = gnt1_cnt_q + 16'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_cnt_q <= 16'd0;
            gnt1_cnt_q <= 16'd0;
        end else begin
            gnt0_cnt_q <= gnt0_cnt_d;
            gnt1_cnt_q <= gnt1_cnt_d;
        end
    end

    assign bus.gnt0_cnt = gnt0_cnt_q;
    assign bus.gnt1_cnt = gnt1_cnt_q;
`endif
endmodule
